// File: rtl/lsu_mc_if.sv
// Data-bus handshake between the LSU (master) and the memory side (slave).
// req/gnt accept a request; rvalid/rdata return load data on a later cycle.
interface lsu_mc_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int MASK_W = XLEN / 8;

  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [MASK_W-1:0] mask;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, mask, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, mask, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: latches a memory op, runs it over the
// req/gnt/rvalid bus while stalling upstream, then retires it for one cycle.
// Misaligned ops are rejected in IDLE without touching the bus.
module lsu_mc #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_ls_valid,
  input  logic [3:0]        I_ls_type,
  input  logic [ADDR_W-1:0] I_memory_addr,
  input  logic [XLEN-1:0]   I_store_data,
  input  logic              I_rd_we,
  input  logic [4:0]        I_rd_waddr,
  input  logic [XLEN-1:0]   I_rd_wdata,
  output logic              O_rd_we,
  output logic [4:0]        O_rd_waddr,
  output logic [XLEN-1:0]   O_rd_wdata,
  output logic              O_stallreq,
  output logic              O_done,
  output logic              O_misalign,
  lsu_mc_if.master          dbus
);
  localparam int OFF_W = $clog2(MASK_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        type_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   st_q;
  logic [XLEN-1:0]   res_q;
  logic              rdwe_q;
  logic [4:0]        waddr_q;

  logic [OFF_W-1:0]  off_in, off_q;
  logic              misal, accept, bus_on;
  logic [MASK_W-1:0] mask_base;
  logic [XLEN-1:0]   shifted, ext;

  assign off_in = I_memory_addr[OFF_W-1:0];
  assign off_q  = addr_q[OFF_W-1:0];
  assign accept = (state_q == IDLE) && I_ls_valid && !misal;

  // Alignment check on the incoming op; D is never legal on a 32-bit path
  always_comb begin
    misal = 1'b0;
    case (I_ls_type[1:0])
      2'b01:   misal = off_in[0];
      2'b10:   misal = |off_in[1:0];
      2'b11:   misal = (XLEN == 32) || (|off_in);
      default: misal = 1'b0;
    endcase
  end

  // Byte strobes for the latched size, then moved to the lane offset
  always_comb begin
    mask_base = '0;
    case (type_q[1:0])
      2'b00:   mask_base = MASK_W'(1);
      2'b01:   mask_base = MASK_W'(3);
      2'b10:   mask_base = MASK_W'(15);
      default: mask_base = '1;
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = dbus.rdata >> {off_q, 3'b000};
    ext     = dbus.rdata;
    case (type_q[1:0])
      2'b00:   ext = type_q[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   ext = type_q[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   ext = type_q[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ext = dbus.rdata;
    endcase
  end

  // Bus drive: live in REQ, held through WAIT, zero otherwise
  always_comb begin
    bus_on     = (state_q == REQ) || (state_q == WAIT);
    dbus.req   = (state_q == REQ);
    dbus.we    = bus_on & type_q[3];
    dbus.addr  = bus_on ? addr_q : '0;
    dbus.mask  = bus_on ? (mask_base << off_q) : '0;
    dbus.wdata = (bus_on && type_q[3]) ? (st_q << {off_q, 3'b000}) : '0;
  end

  // State register; reset aborts any in-flight op immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Op capture on acceptance and load result capture on rvalid in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q  <= '0;
      addr_q  <= '0;
      st_q    <= '0;
      rdwe_q  <= 1'b0;
      waddr_q <= '0;
      res_q   <= '0;
    end else begin
      if (accept) begin
        type_q  <= I_ls_type;
        addr_q  <= I_memory_addr;
        st_q    <= I_store_data;
        rdwe_q  <= I_rd_we;
        waddr_q <= I_rd_waddr;
      end
      if (state_q == WAIT && dbus.rvalid) res_q <= ext;
    end
  end

  // Next state plus writeback/stall/status outputs
  always_comb begin
    state_d    = state_q;
    O_rd_we    = 1'b0;
    O_rd_waddr = '0;
    O_rd_wdata = '0;
    O_stallreq = 1'b0;
    O_done     = 1'b0;
    O_misalign = 1'b0;
    case (state_q)
      IDLE: begin
        if (!I_ls_valid) begin
          O_rd_we    = I_rd_we;
          O_rd_waddr = I_rd_waddr;
          O_rd_wdata = I_rd_wdata;
        end else if (misal) begin
          O_misalign = 1'b1;
        end else begin
          O_stallreq = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        O_stallreq = 1'b1;
        if (dbus.gnt) state_d = type_q[3] ? DONE : WAIT;
      end
      WAIT: begin
        O_stallreq = 1'b1;
        if (dbus.rvalid) state_d = DONE;
      end
      DONE: begin
        O_done     = 1'b1;
        O_rd_we    = rdwe_q & ~type_q[3];
        O_rd_waddr = waddr_q;
        O_rd_wdata = res_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
Multi-cycle load/store unit with a parametrised data path. It replaces the single-cycle memory-stage LSU and sits between the execute/memory pipeline register and the data bus.
- Drives a req/gnt/rvalid handshake to the data bus.
- Stalls the pipeline while a transaction is in flight.
- Supports 64-bit data when XLEN=64.
- Flags misaligned accesses instead of issuing them.
- Passes non-memory writeback through unchanged.

Parameters:
XLEN, 32, data width; legal values are 32 and 64.
ADDR_W, 32, address width.
MASK_W, XLEN/8, byte-strobe width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
I_ls_valid  in  1  memory op present this cycle
I_ls_type  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size (00 B, 01 H, 10 W, 11 D)
I_memory_addr  in  ADDR_W  effective address
I_store_data  in  XLEN  store source, low-aligned
I_rd_we  in  1  writeback enable
I_rd_waddr  in  5  writeback register
I_rd_wdata  in  XLEN  non-load writeback value
O_rd_we  out  1  writeback enable
O_rd_waddr  out  5  writeback register
O_rd_wdata  out  XLEN  writeback value
O_stallreq  out  1  hold upstream pipeline
O_done  out  1  one-cycle pulse: memory op retired
O_misalign  out  1  one-cycle pulse: op rejected
O_dbus_req  out  1  bus request
I_dbus_gnt  in  1  bus accepted request this cycle
O_dbus_we  out  1  store
O_dbus_addr  out  ADDR_W  address
O_dbus_data  out  XLEN  lane-shifted store data
O_dbus_mask  out  MASK_W  byte strobes
I_dbus_rvalid  in  1  load data valid
I_dbus_data  in  XLEN  load data, full bus word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
  - Reset state is IDLE.
  - On reset, all registered fields (type, addr, store data, rd_we, rd_waddr, load result) are cleared to 0.
- Lane offset: off = addr[log2(MASK_W)-1:0].
- Misaligned when any of the following holds:
  - H with off[0]=1;
  - W with off[1:0]≠0;
  - D with off≠0;
  - D when XLEN=32.
- IDLE, I_ls_valid=0:
  - O_rd_* = I_rd_* combinationally.
  - O_stallreq=0, O_dbus_req=0.
- IDLE, I_ls_valid=1, misaligned:
  - O_misalign=1 combinationally.
  - O_rd_we=0, no bus activity, O_stallreq=0.
  - Stay in IDLE.
- IDLE, I_ls_valid=1, aligned:
  - Latch type, addr, store data, rd_we, rd_waddr.
  - O_stallreq=1 in the same cycle.
  - Next state REQ.
- REQ:
  - O_dbus_req=1; addr/we/data/mask are driven from the latched registers and held stable until gnt.
  - gnt=1 with a store: next state DONE (store is complete at grant).
  - gnt=1 with a load: next state WAIT.
  - I_dbus_rvalid is ignored in REQ. The bus returns rvalid no earlier than the cycle after gnt.
- WAIT:
  - O_dbus_req=0.
  - On rvalid: select bytes at lane off, then sign- or zero-extend per [2] to XLEN. D takes the full word. Register the result; next state DONE.
  - No timeout: WAIT is held indefinitely.
- DONE:
  - O_done=1, O_stallreq=0.
  - O_rd_we = latched rd_we & load; O_rd_waddr = latched; O_rd_wdata = latched load result.
  - Next state IDLE unconditionally.
  - A new I_ls_valid in DONE is ignored. Upstream sees stall low, so the new op is presented again in IDLE next cycle.
- O_stallreq = (IDLE & I_ls_valid & aligned) | REQ | WAIT.
- In REQ, WAIT and DONE, O_rd_* ignore I_rd_*.
- Store lane data: O_dbus_data = latched store data shifted left by 8*off.
  - The mask is (1<<bytes)-1 shifted by off, where bytes = 1, 2, 4 or 8 per size.
- Loads drive the same mask as stores; O_dbus_data is 0 on loads.
- Reset mid-transaction:
  - Reset asserted in REQ or WAIT: state goes to IDLE and O_dbus_req drops immediately (asynchronous).
  - A late rvalid arriving after reset is ignored.
- O_dbus_we, O_dbus_addr and O_dbus_mask are 0 whenever O_dbus_req=0, except in the WAIT state, where they hold their values.

Test Plan:
- XLEN=32, lb addr 0x1003, bus returns 0x80112233 one cycle after gnt → rd_wdata 0xFFFFFF80; done pulses in the 4th cycle after valid; stall high for cycles 1-3.
- XLEN=32, sh addr 0x2002, data 0x0000ABCD, gnt delayed 3 cycles → req held 3+1 cycles with data 0xABCD0000 and mask 4'b1100; O_rd_we=0 at done.
- XLEN=64, ld addr 0x8, bus 0x8000_0000_0000_0001 → rd_wdata equals the full word; mask 8'hFF. XLEN=64, lwu addr 0xC, bus upper half 0xF0000000 → rd_wdata 0x00000000F0000000.
- lw addr 0x1002 → O_misalign pulse, no req, stall 0. Same again with XLEN=32 ld addr 0x0 → misalign.
- Non-memory op with rd_we=1, waddr=5, wdata=0x1234 in IDLE → passes through in the same cycle.
- Assert rst while in WAIT → req/stall/done go to 0 immediately; subsequent rvalid produces no done; next lbu addr 0x1 completes normally.
